// File: rtl/sbox_lut_engine.sv
// Time-multiplexed S-box substitution engine with a writable LUT (reset to the Ascon S-box).
// LANES_PER_CYCLE lanes are looked up per BUSY cycle; the table is only writable while IDLE.
module sbox_lut_engine #(
    parameter int unsigned NUM_LANES       = 64,
    parameter int unsigned LANES_PER_CYCLE = 8,
    parameter int unsigned IDX_W           = 5,
    parameter int unsigned ENTRY_W         = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_LANES*IDX_W-1:0]     in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_LANES*ENTRY_W-1:0]   out_data_o,
    input  logic                           wr_en_i,
    output logic                           wr_ready_o,
    input  logic [IDX_W-1:0]               wr_addr_i,
    input  logic [ENTRY_W-1:0]             wr_data_i,
    input  logic                           lock_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned BEATS   = NUM_LANES / LANES_PER_CYCLE;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned DEPTH   = 2 ** IDX_W;
    localparam int unsigned SLICE_W = LANES_PER_CYCLE * ENTRY_W;
    localparam int unsigned IN_W    = NUM_LANES * IDX_W;
    localparam int unsigned OUT_W   = NUM_LANES * ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reset contents: Ascon S-box for the 5x5 configuration, identity otherwise
    function automatic logic [ENTRY_W-1:0] lut_reset_val(input int unsigned idx);
        logic [4:0] s;
        s = 5'h00;
        case (idx)
            0:  s = 5'h04;  1:  s = 5'h0B;  2:  s = 5'h1F;  3:  s = 5'h14;
            4:  s = 5'h1A;  5:  s = 5'h15;  6:  s = 5'h09;  7:  s = 5'h02;
            8:  s = 5'h1B;  9:  s = 5'h05;  10: s = 5'h08;  11: s = 5'h12;
            12: s = 5'h1D;  13: s = 5'h03;  14: s = 5'h06;  15: s = 5'h1C;
            16: s = 5'h1E;  17: s = 5'h13;  18: s = 5'h07;  19: s = 5'h0E;
            20: s = 5'h00;  21: s = 5'h0D;  22: s = 5'h11;  23: s = 5'h18;
            24: s = 5'h10;  25: s = 5'h0C;  26: s = 5'h01;  27: s = 5'h19;
            28: s = 5'h16;  29: s = 5'h0A;  30: s = 5'h0F;  31: s = 5'h17;
            default: s = 5'h00;
        endcase
        if (IDX_W == 5 && ENTRY_W == 5) begin
            return ENTRY_W'(s);
        end
        return ENTRY_W'(idx);
    endfunction

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [IN_W-1:0]     r_idx;
    logic [OUT_W-1:0]    r_res;
    logic [ENTRY_W-1:0]  r_lut [DEPTH];
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_wr_ready;
    logic                r_busy;
    logic                r_err;

    logic [SLICE_W-1:0]  w_slice;

    // Lookup of the lanes belonging to the current beat
    always_comb begin
        w_slice = '0;
        for (int unsigned l = 0; l < LANES_PER_CYCLE; l++) begin
            w_slice[l*ENTRY_W +: ENTRY_W] =
                r_lut[r_idx[(32'(r_beat) * LANES_PER_CYCLE + l) * IDX_W +: IDX_W]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_idx       <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_wr_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned a = 0; a < DEPTH; a++) begin
                r_lut[a] <= lut_reset_val(a);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Table changes only here, so a result never mixes two tables
                    if (wr_en_i) begin
                        if (lock_i) begin
                            r_err <= 1'b1;
                        end else begin
                            r_lut[wr_addr_i] <= wr_data_i;
                        end
                    end
                    if (in_valid_i) begin
                        r_idx      <= in_data_i;
                        r_beat     <= '0;
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b0;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_res[32'(r_beat) * SLICE_W +: SLICE_W] <= w_slice;
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_wr_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_res;
    assign wr_ready_o  = r_wr_ready;
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_sbox_lut_engine.sv
// Bench for sbox_lut_engine: directed vectors and corner sequences on the default
// configuration, plus a randomized sweep over LANES_PER_CYCLE = 1, 8, 64.
module tb_sbox_lut_engine;

    localparam int unsigned NL = 64;
    localparam int unsigned W  = NL * 5;

    logic clk;
    logic rst;
    logic           in_valid  [3];
    logic           in_ready  [3];
    logic [W-1:0]   in_data   [3];
    logic           out_valid [3];
    logic           out_ready [3];
    logic [W-1:0]   out_data  [3];
    logic           wr_en     [3];
    logic           wr_ready  [3];
    logic [4:0]     wr_addr   [3];
    logic [4:0]     wr_data   [3];
    logic           lock      [3];
    logic           busy      [3];
    logic           err       [3];

    int n_pass;
    int n_total;
    int lpcs [3];
    logic [4:0] ascon [32];
    logic [4:0] mlut [3][32];

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs [4];

    sbox_lut_engine #(.NUM_LANES(NL), .LANES_PER_CYCLE(1), .IDX_W(5), .ENTRY_W(5)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .wr_en_i(wr_en[0]), .wr_ready_o(wr_ready[0]),
        .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data[0]), .lock_i(lock[0]),
        .busy_o(busy[0]), .err_o(err[0]));

    sbox_lut_engine #(.NUM_LANES(NL), .LANES_PER_CYCLE(8), .IDX_W(5), .ENTRY_W(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .wr_en_i(wr_en[1]), .wr_ready_o(wr_ready[1]),
        .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1]), .lock_i(lock[1]),
        .busy_o(busy[1]), .err_o(err[1]));

    sbox_lut_engine #(.NUM_LANES(NL), .LANES_PER_CYCLE(64), .IDX_W(5), .ENTRY_W(5)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .in_data_i(in_data[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .out_data_o(out_data[2]), .wr_en_i(wr_en[2]), .wr_ready_o(wr_ready[2]),
        .wr_addr_i(wr_addr[2]), .wr_data_i(wr_data[2]), .lock_i(lock[2]),
        .busy_o(busy[2]), .err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference: each lane index looked up in the bench's copy of the table
    function automatic logic [W-1:0] model(input int d, input logic [W-1:0] data);
        logic [W-1:0] r;
        logic [4:0] ix;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            ix = data[i*5 +: 5];
            r[i*5 +: 5] = mlut[d][ix];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] fill_lanes(input logic [4:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < NL; i++) r[i*5 +: 5] = v;
        return r;
    endfunction

    task automatic reset_models();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 32; a++) mlut[d][a] = ascon[a];
    endtask

    // Present a request at a negedge; returns after the accepting edge
    task automatic start_req(input int d, input logic [W-1:0] data);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        wr_en[d]    = 1'b0;
    endtask

    task automatic wait_done(input int d, output logic [W-1:0] res, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy[d]) bc++;
            if (out_valid[d]) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid[d]) chk("out_valid timeout", {{(W-1){1'b0}}, out_valid[d]}, W'(1));
        res = out_data[d];
    endtask

    task automatic handshake(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic do_wr(input int d, input logic [4:0] a, input logic [4:0] v);
        chk("wr_ready in idle", W'(wr_ready[d]), W'(1));
        wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v; lock[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wr_en[d] = 1'b0;
        mlut[d][a] = v;
    endtask

    function automatic logic [4:0] st_flags(input int d);
        return {in_ready[d], out_valid[d], busy[d], err[d], wr_ready[d]};
    endfunction

    logic [W-1:0] res;
    logic [W-1:0] ramp;
    logic [W-1:0] data;
    logic [W-1:0] vres1;
    int lat, bc, bad, stall;

    initial begin
        n_pass = 0; n_total = 0;
        lpcs = '{1, 8, 64};
        ascon = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                  5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                  5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                  5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 0; in_data[d] = '0; out_ready[d] = 0; wr_en[d] = 0;
            wr_addr[d] = '0; wr_data[d] = '0; lock[d] = 0;
        end
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NL; i++) begin
                logic [4:0] ix;
                case (v)
                    0: ix = 5'd0;
                    1: ix = 5'(i % 32);
                    2: ix = 5'd31;
                    default: ix = 5'((i * 7 + 3) % 32);
                endcase
                vecs[v].data[i*5 +: 5] = ix;
                vecs[v].exp[i*5 +: 5]  = ascon[ix];
            end
        end
        ramp = vecs[1].data;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_models();

        for (int d = 0; d < 3; d++) begin
            chk("reset flags", W'(st_flags(d)), W'(5'b10001));
            chk("reset out_data", out_data[d], '0);
        end

        // Directed vectors on the default configuration, each held 5 cycles before handshake
        for (int v = 0; v < 4; v++) begin
            start_req(1, vecs[v].data);
            wait_done(1, res, lat, bc);
            chk("vec latency", W'(lat), W'(9));
            chk("vec busy cycles", W'(bc), W'(9));
            chk("vec data", res, vecs[v].exp);
            if (v == 1) vres1 = res;
            bad = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_data[1] !== res || in_ready[1] || !out_valid[1]) bad++;
            end
            chk("stall stable", W'(bad), W'(0));
            handshake(1);
            chk("idle after handshake", W'({in_ready[1], busy[1]}), W'(2'b10));
        end
        chk("lane1", W'(vres1[1*5 +: 5]), W'(5'h0B));
        chk("lane31", W'(vres1[31*5 +: 5]), W'(5'h17));
        chk("lane32", W'(vres1[32*5 +: 5]), W'(5'h04));

        // Write and request in the same IDLE cycle: new table applies
        wr_en[1] = 1'b1; wr_addr[1] = 5'h00; wr_data[1] = 5'h1F; lock[1] = 1'b0;
        start_req(1, '0);
        mlut[1][0] = 5'h1F;
        wait_done(1, res, lat, bc);
        chk("same-cycle write", res, fill_lanes(5'h1F));
        handshake(1);

        // Write held during BUSY: stalled until IDLE, current result uses old table
        start_req(1, '0);
        wr_en[1] = 1'b1; wr_addr[1] = 5'h00; wr_data[1] = 5'h02;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (wr_ready[1]) bad++;
            if (out_valid[1]) break;
            @(posedge clk);
            @(negedge clk);
        end
        res = out_data[1];
        chk("wr_ready low while busy", W'(bad), W'(0));
        chk("old table during write", res, fill_lanes(5'h1F));
        handshake(1);
        chk("wr_ready back in idle", W'(wr_ready[1]), W'(1));
        @(posedge clk);
        @(negedge clk);
        wr_en[1] = 1'b0;
        mlut[1][0] = 5'h02;
        start_req(1, '0);
        wait_done(1, res, lat, bc);
        chk("deferred write landed", res, model(1, '0));
        chk("deferred lane0", W'(res[4:0]), W'(5'h02));
        handshake(1);

        // Locked write is dropped and flags err
        wr_en[1] = 1'b1; wr_addr[1] = 5'h03; wr_data[1] = 5'h00; lock[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en[1] = 1'b0; lock[1] = 1'b0;
        chk("err set", W'(err[1]), W'(1));
        start_req(1, fill_lanes(5'h03));
        wait_done(1, res, lat, bc);
        chk("locked entry kept", W'(res[4:0]), W'(5'h14));
        chk("locked data", res, model(1, fill_lanes(5'h03)));
        handshake(1);
        chk("err sticky", W'(err[1]), W'(1));

        // Reset in the middle of BUSY
        start_req(1, ramp);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_models();
        chk("mid-busy reset flags", W'(st_flags(1)), W'(5'b10001));
        chk("mid-busy reset data", out_data[1], '0);
        start_req(1, ramp);
        wait_done(1, res, lat, bc);
        chk("lut restored", res, vecs[1].exp);
        chk("lut restored lane0", W'(res[4:0]), W'(5'h04));
        handshake(1);

        // Randomized back-to-back requests on every configuration
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 12; n++) begin
                if ($urandom_range(0, 3) == 0) do_wr(d, 5'($urandom), 5'($urandom));
                for (int i = 0; i < NL; i++) data[i*5 +: 5] = 5'($urandom);
                start_req(d, data);
                wait_done(d, res, lat, bc);
                chk("rand latency", W'(lat), W'(NL / lpcs[d] + 1));
                chk("rand data", res, model(d, data));
                stall = $urandom_range(0, 2);
                repeat (stall) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                handshake(d);
                chk("rand ready", W'(in_ready[d]), W'(1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
